// File: rtl/bram_sched_pkg.sv
// Shared requester IDs, tag types and helpers for the BRAM request scheduler.
// Requester ID order (cache, dma, pref) is also the round-robin and fixed-priority order.
package bram_sched_pkg;
  typedef logic [1:0] tag_t;

  localparam int   NUM_REQ   = 3;
  localparam tag_t REQ_CACHE = 2'd0;
  localparam tag_t REQ_DMA   = 2'd1;
  localparam tag_t REQ_PREF  = 2'd2;
  localparam int   WAIT_W    = 4;

  function automatic tag_t next_req(input tag_t id);
    return (id == REQ_PREF) ? REQ_CACHE : id + 2'd1;
  endfunction
endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-depth {valid, tag} delay line: the input appears at the output DEPTH cycles later.
// It has no backpressure and shifts every cycle; reset drops every in-flight entry.
module rd_tag_pipe
  import bram_sched_pkg::*;
#(
  parameter int DEPTH = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_vld,
  input  logic [1:0] i_tag,
  output logic       o_vld,
  output logic [1:0] o_tag
);
  logic r_vld [DEPTH];
  tag_t r_tag [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i] <= 1'b0;
        r_tag[i] <= REQ_CACHE;
      end
    end else begin
      r_vld[0] <= i_vld;
      r_tag[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign o_vld = r_vld[DEPTH-1];
  assign o_tag = r_tag[DEPTH-1];
endmodule

// File: rtl/bram_req_scheduler.sv
// Three-way BRAM port arbiter: combinational grant, registered issue one cycle later, rvalid READ_LAT cycles after issue.
// Losing requesters simply hold req; a starved requester pre-empts round-robin in fixed order cache > dma > pref.
module bram_req_scheduler
  import bram_sched_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int READ_LAT   = 10,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cache_req,
  input  logic [ADDR_W-1:0] cache_addr,
  output logic              cache_gnt,
  output logic              cache_rvalid,
  input  logic              pref_req,
  input  logic [ADDR_W-1:0] pref_addr,
  output logic              pref_gnt,
  output logic              pref_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic              bram_in_valid,
  output logic              bram_wr,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_di,
  input  logic              bram_do_valid
);
  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_gnt;
  logic [WAIT_W-1:0]  r_wait [NUM_REQ];
  tag_t               r_rr_ptr;
  logic               w_any_gnt;
  tag_t               w_gnt_id;
  tag_t               w_cand;
  logic               w_sel_wr;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_di;
  logic               r_iss_vld;
  logic               r_iss_wr;
  tag_t               r_iss_tag;
  logic [ADDR_W-1:0]  r_iss_addr;
  logic [DATA_W-1:0]  r_iss_di;
  logic               w_rd_vld;
  logic [1:0]         w_rd_tag;

  assign w_req = {pref_req, dma_req, cache_req};

  always_comb begin
    w_any_gnt = 1'b0;
    w_gnt_id  = REQ_CACHE;
    w_cand    = REQ_CACHE;
    // Scan downwards so the lowest ID / nearest-to-pointer requester wins.
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (w_req[i] && (r_wait[i] >= WAIT_W'(STARVE_LIM))) begin
        w_any_gnt = 1'b1;
        w_gnt_id  = tag_t'(i);
      end
    end
    if (!w_any_gnt) begin
      for (int k = NUM_REQ-1; k >= 0; k--) begin
        w_cand = tag_t'((int'(r_rr_ptr) + k) % NUM_REQ);
        if (w_req[w_cand]) begin
          w_any_gnt = 1'b1;
          w_gnt_id  = w_cand;
        end
      end
    end
  end

  assign cache_gnt = w_any_gnt && (w_gnt_id == REQ_CACHE);
  assign dma_gnt   = w_any_gnt && (w_gnt_id == REQ_DMA);
  assign pref_gnt  = w_any_gnt && (w_gnt_id == REQ_PREF);
  assign w_gnt     = {pref_gnt, dma_gnt, cache_gnt};

  always_comb begin
    w_sel_wr   = 1'b0;
    w_sel_addr = '0;
    w_sel_di   = '0;
    if (w_any_gnt) begin
      case (w_gnt_id)
        REQ_CACHE: w_sel_addr = cache_addr;
        REQ_DMA: begin
          w_sel_addr = dma_addr;
          w_sel_wr   = dma_we;
          w_sel_di   = dma_we ? dma_wdata : '0;
        end
        REQ_PREF:  w_sel_addr = pref_addr;
        default:   w_sel_addr = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= REQ_CACHE;
      r_iss_vld  <= 1'b0;
      r_iss_wr   <= 1'b0;
      r_iss_tag  <= REQ_CACHE;
      r_iss_addr <= '0;
      r_iss_di   <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_wait[i] <= '0;
    end else begin
      if (w_any_gnt) r_rr_ptr <= next_req(w_gnt_id);
      r_iss_vld  <= w_any_gnt;
      r_iss_wr   <= w_sel_wr;
      r_iss_tag  <= w_gnt_id;
      r_iss_addr <= w_sel_addr;
      r_iss_di   <= w_sel_di;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_req[i] || w_gnt[i]) r_wait[i] <= '0;
        else if (r_wait[i] != '1) r_wait[i] <= r_wait[i] + 1'b1;
      end
    end
  end

  assign bram_in_valid = r_iss_vld;
  assign bram_wr       = r_iss_wr;
  assign bram_addr     = r_iss_addr;
  assign bram_di       = r_iss_di;

  // Writes travel as bubbles so the pipe stays aligned with issue order.
  rd_tag_pipe #(.DEPTH(READ_LAT)) u_rd_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (r_iss_vld && !r_iss_wr),
    .i_tag (r_iss_tag),
    .o_vld (w_rd_vld),
    .o_tag (w_rd_tag)
  );

  assign cache_rvalid = w_rd_vld && (w_rd_tag == REQ_CACHE);
  assign dma_rvalid   = w_rd_vld && (w_rd_tag == REQ_DMA);
  assign pref_rvalid  = w_rd_vld && (w_rd_tag == REQ_PREF);

  a_rvalid_matches_bram: assert property (@(posedge clk) disable iff (!rst_n) w_rd_vld == bram_do_valid)
    else $error("rvalid out of step with bram_do_valid");
endmodule

// File: tb/tb_bram_req_scheduler.sv
// Directed and random stimulus for bram_req_scheduler against a cycle-level reference model.
// STARVE_LIM is 1 here so starvation grants visibly override the round-robin choice.
module tb_bram_req_scheduler;
  localparam int ADDR_W     = 13;
  localparam int DATA_W     = 32;
  localparam int READ_LAT   = 10;
  localparam int STARVE_LIM = 1;
  localparam int MAXC       = 1200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cache_req = 1'b0, pref_req = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [ADDR_W-1:0] cache_addr = '0, pref_addr = '0, dma_addr = '0;
  logic [DATA_W-1:0] dma_wdata = '0;
  logic bram_do_valid = 1'b0;
  logic cache_gnt, cache_rvalid, pref_gnt, pref_rvalid, dma_gnt, dma_rvalid;
  logic bram_in_valid, bram_wr;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_di;

  bram_req_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .cache_req(cache_req), .cache_addr(cache_addr), .cache_gnt(cache_gnt), .cache_rvalid(cache_rvalid),
    .pref_req(pref_req), .pref_addr(pref_addr), .pref_gnt(pref_gnt), .pref_rvalid(pref_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .bram_in_valid(bram_in_valid), .bram_wr(bram_wr), .bram_addr(bram_addr), .bram_di(bram_di),
    .bram_do_valid(bram_do_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: bit index = requester ID (0 cache, 1 dma, 2 pref).
  int                m_ptr;
  int                m_wait [3];
  logic              m_iv, m_iwr;
  logic [ADDR_W-1:0] m_iaddr;
  logic [DATA_W-1:0] m_idi;
  logic [2:0]        m_gnt;
  logic [2:0]        exp_rv [MAXC];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    logic [2:0] r;
    logic [2:0] rv;
    int g;
    if (!rst_n) begin
      m_ptr = 0;
      for (int i = 0; i < 3; i++) m_wait[i] = 0;
      m_iv = 1'b0; m_iwr = 1'b0; m_iaddr = '0; m_idi = '0;
      for (int i = cyc; i < MAXC; i++) exp_rv[i] = 3'b000;
    end
    r = {pref_req, dma_req, cache_req};
    g = -1;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) if (g < 0 && r[i] && m_wait[i] >= STARVE_LIM) g = i;
      for (int k = 0; k < 3; k++) if (g < 0 && r[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
    end
    m_gnt = (g >= 0) ? (3'b001 << g) : 3'b000;
    rv = exp_rv[cyc];
    bram_do_valid = rst_n && (rv != 3'b000);
    @(negedge clk);
    chk("gnt", 64'({pref_gnt, dma_gnt, cache_gnt}), 64'(m_gnt));
    chk("in_valid", 64'(bram_in_valid), 64'(m_iv));
    chk("wr", 64'(bram_wr), 64'(m_iwr));
    if (m_iv) begin
      chk("addr", 64'(bram_addr), 64'(m_iaddr));
      chk("di", 64'(bram_di), 64'(m_idi));
    end
    chk("rvalid", 64'({pref_rvalid, dma_rvalid, cache_rvalid}), 64'(rv));
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (!r[i] || m_gnt[i]) m_wait[i] = 0;
        else if (m_wait[i] < 15) m_wait[i]++;
      end
      m_iv    = (g >= 0);
      m_iwr   = (g == 1) && dma_we;
      m_iaddr = (g == 0) ? cache_addr : (g == 1) ? dma_addr : (g == 2) ? pref_addr : '0;
      m_idi   = m_iwr ? dma_wdata : '0;
      if (g >= 0) begin
        m_ptr = (g + 1) % 3;
        if (!m_iwr && (cyc + 1 + READ_LAT) < MAXC) exp_rv[cyc + 1 + READ_LAT][g] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Granted requesters drop req unless listed in keep (then they re-request a new address).
  task automatic run(input int n, input logic [2:0] keep);
    for (int c = 0; c < n; c++) begin
      tick();
      if (m_gnt[0]) begin cache_req = keep[0]; cache_addr = ADDR_W'($urandom); end
      if (m_gnt[1]) begin dma_req = keep[1]; dma_addr = ADDR_W'($urandom); end
      if (m_gnt[2]) begin pref_req = keep[2]; pref_addr = ADDR_W'($urandom); end
    end
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) exp_rv[i] = 3'b000;
    @(posedge clk);
    #1;
    run(3, 3'b000);
    chk("reset_addr", 64'(bram_addr), 64'd0);
    chk("reset_di", 64'(bram_di), 64'd0);
    rst_n = 1'b1;

    // Single cache read; rvalid expected 11 cycles after the grant.
    cache_req = 1'b1; cache_addr = 13'h010;
    run(1, 3'b000);
    run(12, 3'b000);

    // All three held, DMA reading.
    cache_req = 1'b1; dma_req = 1'b1; pref_req = 1'b1; dma_we = 1'b0;
    run(12, 3'b111);
    cache_req = 1'b0; dma_req = 1'b0; pref_req = 1'b0;
    run(12, 3'b000);

    // DMA write: issued with data, never returns rvalid.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 13'h100; dma_wdata = 32'hDEADBEEF;
    run(1, 3'b000);
    dma_we = 1'b0;
    run(13, 3'b000);

    // Prefetch pulse withdrawn while competing.
    cache_req = 1'b1; dma_req = 1'b1; pref_req = 1'b1;
    run(1, 3'b000);
    pref_req = 1'b0;
    run(4, 3'b000);

    // Three reads in flight, then reset three cycles later.
    cache_req = 1'b1; dma_req = 1'b1; pref_req = 1'b1;
    run(3, 3'b000);
    cache_req = 1'b0; dma_req = 1'b0; pref_req = 1'b0;
    run(3, 3'b000);
    rst_n = 1'b0;
    run(1, 3'b000);
    rst_n = 1'b1;
    run(12, 3'b000);
    cache_req = 1'b1; dma_req = 1'b1; pref_req = 1'b1;
    run(1, 3'b000);
    chk("post_reset_first_gnt", 64'(m_gnt), 64'(3'b001));
    run(3, 3'b000);

    // Random traffic with occasional withdrawals.
    for (int c = 0; c < 600; c++) begin
      if (!cache_req) begin
        cache_req = ($urandom_range(1, 0) == 1); cache_addr = ADDR_W'($urandom);
      end else if ($urandom_range(7, 0) == 0) cache_req = 1'b0;
      if (!dma_req) begin
        dma_req = ($urandom_range(1, 0) == 1); dma_addr = ADDR_W'($urandom);
        dma_we = ($urandom_range(2, 0) == 0); dma_wdata = $urandom;
      end else if ($urandom_range(7, 0) == 0) dma_req = 1'b0;
      if (!pref_req) begin
        pref_req = ($urandom_range(1, 0) == 1); pref_addr = ADDR_W'($urandom);
      end else if ($urandom_range(7, 0) == 0) pref_req = 1'b0;
      run(1, 3'b000);
    end
    cache_req = 1'b0; dma_req = 1'b0; pref_req = 1'b0;
    run(13, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
